// File: rtl/ctrdivn_pkg.sv
// rtl/ctrdivn_pkg.sv - shared types and helpers for the programmable divide-by-N enable generator
//
// Purpose: output-mode encoding, default sizing and the half-period helper
// shared by the divider and its users.
package ctrdivn_pkg;

   typedef enum logic {
      MODE_PULSE  = 1'b0,
      MODE_SQUARE = 1'b1
   } ctrdivn_mode_t;

   localparam int CTRDIVN_W_DEFAULT = 8;
   localparam int CTRDIVN_N_DEFAULT = 10;

   // Number of high counts in square mode: ceil(n/2).
   function automatic int unsigned ctrdivn_half(input int unsigned n);
      return (n + 1) / 2;
   endfunction

endpackage

// File: rtl/ctrdivn_prog.sv
// rtl/ctrdivn_prog.sv - programmable divide-by-N clock-enable generator with glitch-free divisor reload
//
// Purpose: counts enable_in-qualified cycles modulo the active divisor and
// produces either a one-cycle pulse per period or a near-50% square wave.
// A new divisor is captured into a shadow register and only becomes active
// on a period boundary (wrap edge), so a period is never cut short.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   enable_in     count qualifier
//   div_in        new divisor (0 is treated as 1), sampled when load_in=1
//   load_in       capture div_in into the shadow register
//   mode_in       0 = pulse, 1 = square
//   divn_out      divided output (registered)
//   cnt_out       current counter value (registered)
//   load_ack_out  one-cycle pulse after the edge where a new divisor became active
module ctrdivn_prog
   import ctrdivn_pkg::*;
#(
   parameter int W         = CTRDIVN_W_DEFAULT,
   parameter int DEFAULT_N = CTRDIVN_N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable_in,
   input  logic [W-1:0] div_in,
   input  logic         load_in,
   input  logic         mode_in,
   output logic         divn_out,
   output logic [W-1:0] cnt_out,
   output logic         load_ack_out
);

   localparam logic [W-1:0] RESET_N = W'(DEFAULT_N);

   logic [W-1:0]  cnt;
   logic [W-1:0]  cnt_next;
   logic [W-1:0]  active_n;
   logic [W-1:0]  shadow_n;
   logic [W-1:0]  div_clean;
   logic [W:0]    half_n;
   logic          pending;
   logic          wrap;
   logic          divn;
   logic          load_ack;
   ctrdivn_mode_t mode;

   assign mode      = ctrdivn_mode_t'(mode_in);
   assign div_clean = (div_in == '0) ? W'(1) : div_in;
   assign half_n    = (W+1)'(ctrdivn_half(32'(active_n)));

   // The wrap edge is the period boundary: the only place the divisor may change.
   assign wrap = enable_in && (cnt == active_n - W'(1));

   always_comb begin
      cnt_next = cnt;
      if (enable_in) begin
         cnt_next = wrap ? '0 : cnt + W'(1);
      end
   end

   // Counter and divided output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         divn <= 1'b0;
      end else begin
         cnt <= cnt_next;
         if (mode == MODE_PULSE) begin
            divn <= wrap;
         end else if (enable_in) begin
            // Square output is a function of the count being entered, so it
            // lines up with cnt_out; it holds while counting is paused.
            divn <= ({1'b0, cnt_next} < half_n);
         end
      end
   end

   // Shadow register and commit at the period boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_n <= RESET_N;
         shadow_n <= RESET_N;
         pending  <= 1'b0;
         load_ack <= 1'b0;
      end else begin
         load_ack <= 1'b0;
         if (load_in) begin
            shadow_n <= div_clean;
            pending  <= 1'b1;
         end
         // A load arriving on the wrap edge itself bypasses the shadow so the
         // new divisor governs the period that starts now.
         if (wrap && (pending || load_in)) begin
            active_n <= load_in ? div_clean : shadow_n;
            pending  <= 1'b0;
            load_ack <= 1'b1;
         end
      end
   end

   assign divn_out     = divn;
   assign cnt_out      = cnt;
   assign load_ack_out = load_ack;

endmodule
